// File: rtl/mod_counter_bcd.sv
// Modulo up/down counter with synchronous load, terminal-count pulse and a
// multi-cycle shift-add-3 binary-to-BCD converter. Define MOD_COUNTER_BCD_SATURATE_EN to saturate instead of wrap.

module mod_counter_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module mod_counter_bcd #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 200,
  parameter int DIGITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0]   MOD_W     = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] Q_MAX     = WIDTH'(MODULUS - 1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(WIDTH - 1);

  // Value taken at the limit when counting past it.
`ifdef MOD_COUNTER_BCD_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_LIM_NXT = Q_MAX;
  localparam logic [WIDTH-1:0] DN_LIM_NXT = '0;
`else
  localparam logic [WIDTH-1:0] UP_LIM_NXT = '0;
  localparam logic [WIDTH-1:0] DN_LIM_NXT = Q_MAX;
`endif

  typedef enum logic {IDLE, CONV} state_t;

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         cap;
  logic [WIDTH-1:0]         sreg;
  logic [SW-1:0]            step;
  logic [DIGITS-1:0][3:0]   acc;
  logic [DIGITS-1:0][3:0]   acc_adj;
  logic [DIGITS-1:0][3:0]   acc_nxt;
  logic [BW-1:0]            adj_flat;
  logic                     unused_msb;

  // Counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q <= ({1'b0, d} < MOD_W) ? d : Q_MAX;
      end else if (en) begin
        if (up) begin
          if (q == Q_MAX) begin
            q  <= UP_LIM_NXT;
            tc <= 1'b1;
          end else begin
            q <= q + WIDTH'(1);
          end
        end else begin
          if (q == '0) begin
            q  <= DN_LIM_NXT;
            tc <= 1'b1;
          end else begin
            q <= q - WIDTH'(1);
          end
        end
      end
    end
  end

  // Per-digit add-3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    mod_counter_bcd_add3 u_add3 (.din(acc[g]), .dout(acc_adj[g]));
  end

  // Top bit of the most significant digit never carries for legal WIDTH/DIGITS.
  assign adj_flat   = acc_adj;
  assign unused_msb = adj_flat[BW-1];
  assign acc_nxt    = {adj_flat[BW-2:0], sreg[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (q != cap)          state_nxt = CONV;
      CONV: if (step == STEP_LAST) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap  <= '0;
      sreg <= '0;
      acc  <= '0;
      step <= '0;
      bcd  <= '0;
    end else begin
      case (state)
        IDLE: if (q != cap) begin
          cap  <= q;
          sreg <= q;
          acc  <= '0;
          step <= '0;
        end
        CONV: begin
          acc  <= acc_nxt;
          sreg <= sreg << 1;
          step <= step + SW'(1);
          if (step == STEP_LAST) bcd <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bcd_valid = (state == IDLE) && (q == cap);

endmodule

// File: tb/tb_mod_counter_bcd.sv
// Directed table-driven bench for mod_counter_bcd at default parameters,
// plus hand sequences for wrap/saturate, back-to-back changes and reset mid-conversion.

module tb_mod_counter_bcd;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [7:0]  d, q;
  logic        tc, bcd_valid;
  logic [11:0] bcd;

  int n_chk  = 0;
  int n_fail = 0;

  mod_counter_bcd dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q), .tc(tc), .bcd(bcd), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        load, en, up;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        tc;
    logic [11:0] bcd;
    int          lat;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycles (sampled #1 after each edge) until bcd_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bcd_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL wait_valid: bcd_valid still %0b after %0d cycles", bcd_valid, n);
    end
  endtask

  task automatic step(input logic l, input logic e, input logic u, input logic [7:0] dv);
    @(negedge clk);
    load = l; en = e; up = u; d = dv;
    @(posedge clk); #1;
    load = 1'b0; en = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; d = '0;
    vt[0] = '{1'b1, 1'b0, 1'b0, 8'd123, 8'd123, 1'b0, 12'h123, 9};
    vt[1] = '{1'b1, 1'b0, 1'b0, 8'd250, 8'd199, 1'b0, 12'h199, 9};
    vt[2] = '{1'b1, 1'b0, 1'b0, 8'd200, 8'd199, 1'b0, 12'h199, 0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 8'd199, 8'd199, 1'b0, 12'h199, 0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 12'h000, 9};
    vt[5] = '{1'b1, 1'b0, 1'b0, 8'd5,   8'd5,   1'b0, 12'h005, 9};
    vt[6] = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd4,   1'b0, 12'h004, 9};
    vt[7] = '{1'b0, 1'b0, 1'b1, 8'd77,  8'd4,   1'b0, 12'h004, 0};
    vt[8] = '{1'b1, 1'b0, 1'b0, 8'd99,  8'd99,  1'b0, 12'h099, 9};
    vt[9] = '{1'b0, 1'b1, 1'b1, 8'd0,   8'd100, 1'b0, 12'h100, 9};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0); chk("rst_tc", tc, 0);
    chk("rst_bcd", bcd, 0); chk("rst_valid", bcd_valid, 1);
    @(negedge clk); rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("idle_q", q, 0); chk("idle_valid", bcd_valid, 1); chk("idle_bcd", bcd, 0);
    end

    for (int i = 0; i < 10; i++) begin
      step(vt[i].load, vt[i].en, vt[i].up, vt[i].d);
      chk($sformatf("v%0d_q", i), q, vt[i].q);
      chk($sformatf("v%0d_tc", i), tc, vt[i].tc);
      wait_valid(n);
      chk($sformatf("v%0d_lat", i), n, vt[i].lat);
      chk($sformatf("v%0d_bcd", i), bcd, vt[i].bcd);
    end

    // Up past the top limit for two enabled cycles
    step(1'b1, 1'b0, 1'b0, 8'd199);
    wait_valid(n);
    @(negedge clk); en = 1'b1; up = 1'b1;
    @(posedge clk); #1;
`ifdef MOD_COUNTER_BCD_SATURATE_EN
    chk("up1_q", q, 199); chk("up1_tc", tc, 1);
    @(posedge clk); #1;
    chk("up2_q", q, 199); chk("up2_tc", tc, 1);
`else
    chk("up1_q", q, 0); chk("up1_tc", tc, 1);
    @(posedge clk); #1;
    chk("up2_q", q, 1); chk("up2_tc", tc, 0);
`endif
    en = 1'b0;
    @(posedge clk); #1;
    chk("up_tc_off", tc, 0);
    wait_valid(n);
`ifdef MOD_COUNTER_BCD_SATURATE_EN
    chk("up_bcd", bcd, 12'h199);
`else
    chk("up_bcd", bcd, 12'h001);
`endif

    // Down past zero
    step(1'b1, 1'b0, 1'b0, 8'd0);
    wait_valid(n);
    step(1'b0, 1'b1, 1'b0, 8'd0);
`ifdef MOD_COUNTER_BCD_SATURATE_EN
    chk("dn_q", q, 0);
`else
    chk("dn_q", q, 199);
`endif
    chk("dn_tc", tc, 1);
    @(posedge clk); #1;
    chk("dn_tc_off", tc, 0);
    wait_valid(n);
`ifdef MOD_COUNTER_BCD_SATURATE_EN
    chk("dn_bcd", bcd, 12'h000);
`else
    chk("dn_bcd", bcd, 12'h199);
`endif

    // Three back-to-back increments: second change lands mid-conversion
    step(1'b1, 1'b0, 1'b0, 8'd5);
    wait_valid(n);
    @(negedge clk); en = 1'b1; up = 1'b1;
    @(posedge clk); #1; chk("bb_q6", q, 6); chk("bb_v6", bcd_valid, 0);
    @(posedge clk); #1; chk("bb_q7", q, 7);
    @(posedge clk); #1; chk("bb_q8", q, 8);
    en = 1'b0;
    wait_valid(n);
    chk("bb_in_budget", (n <= 18) ? 1 : 0, 1);
    chk("bb_bcd", bcd, 12'h008);

    // Reset four cycles into a conversion
    step(1'b1, 1'b0, 1'b0, 8'd123);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr_q", q, 0); chk("mr_bcd", bcd, 0);
    chk("mr_valid", bcd_valid, 1); chk("mr_tc", tc, 0);
    @(negedge clk); rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      chk("mr_hold_bcd", bcd, 0); chk("mr_hold_valid", bcd_valid, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
